// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with a DEPTH-entry write FIFO and a runtime frame format.
// Frames chain back-to-back while the FIFO holds data.
module uart_tx_fifo_cfg #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             baud_tick_1x,
  input  logic [1:0]       cfg_data_bits,
  input  logic             cfg_parity_en,
  input  logic             cfg_parity_odd,
  input  logic             cfg_stop2,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             tx_line,
  output logic             tx_busy,
  output logic             tx_done,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       nb_q, nb_d;
  logic             pen_q, pen_d;
  logic             stop2_q, stop2_d;
  logic             par_q, par_d;
  logic             line_q, line_d;
  logic             done_q, done_d;
  logic             push, load, eof;
  logic             has_data, last_bit;

  assign push     = tx_valid && tx_ready;
  assign has_data = (count_q != '0);
  assign last_bit = (bit_q == (3'd4 + {1'b0, nb_q}));

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      nb_q     <= '0;
      pen_q    <= 1'b0;
      stop2_q  <= 1'b0;
      par_q    <= 1'b0;
      line_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      nb_q    <= nb_d;
      pen_q   <= pen_d;
      stop2_q <= stop2_d;
      par_q   <= par_d;
      line_q  <= line_d;
      done_q  <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, load})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    nb_d    = nb_q;
    pen_d   = pen_q;
    stop2_d = stop2_q;
    par_d   = par_q;
    line_d  = line_q;
    done_d  = 1'b0;
    load    = 1'b0;
    eof     = 1'b0;
    if (baud_tick_1x) begin
      unique case (state_q)
        S_IDLE: load = has_data;
        S_START: begin
          line_d  = shift_q[0];
          par_d   = par_q ^ shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
          state_d = S_DATA;
        end
        S_DATA: begin
          if (last_bit) begin
            line_d  = pen_q ? par_q : 1'b1;
            state_d = pen_q ? S_PARITY : S_STOP1;
          end else begin
            line_d  = shift_q[0];
            par_d   = par_q ^ shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
        S_PARITY: begin
          line_d  = 1'b1;
          state_d = S_STOP1;
        end
        S_STOP1: begin
          if (stop2_q) state_d = S_STOP2;
          else         eof     = 1'b1;
        end
        S_STOP2: eof = 1'b1;
        default: state_d = S_IDLE;
      endcase
      if (eof) begin
        done_d = 1'b1;
        load   = has_data;
        if (!has_data) begin
          state_d = S_IDLE;
          line_d  = 1'b1;
        end
      end
      // Frame start: parity seeds with the odd flag, format is frozen here.
      if (load) begin
        state_d = S_START;
        shift_d = mem_q[rd_ptr_q];
        nb_d    = cfg_data_bits;
        pen_d   = cfg_parity_en;
        stop2_d = cfg_stop2;
        par_d   = cfg_parity_odd;
        bit_d   = '0;
        line_d  = 1'b0;
      end
    end
  end

  always_comb begin
    tx_line    = line_q;
    tx_busy    = (state_q != S_IDLE);
    tx_done    = done_q;
    tx_ready   = (count_q != FULL);
    fifo_count = count_q;
  end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Scoreboard bench for uart_tx_fifo_cfg: expected line bits are queued
// by the stimulus and checked by a monitor thread at every baud tick.
module tb_uart_tx_fifo_cfg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gen_tick = 1'b0;
  logic       man_tick = 1'b0;
  logic       baud_tick;
  logic [1:0] cfg_data_bits = 2'd3;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_parity_odd = 1'b0;
  logic       cfg_stop2 = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_line, tx_busy, tx_done;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int tcnt = 0;
  bit tick_en = 1'b0;
  bit mon_en = 1'b0;
  bit exp_q[$];

  assign baud_tick = gen_tick | man_tick;

  uart_tx_fifo_cfg #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick_1x(baud_tick),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_line(tx_line), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (tick_en && tcnt == 5) begin
      gen_tick = 1'b1;
      tcnt = 0;
    end else begin
      gen_tick = 1'b0;
      tcnt = tick_en ? tcnt + 1 : 0;
    end
  end

  always @(negedge clk) if (tx_done) done_cnt++;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic monitor();
    bit e;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en && baud_tick && tx_busy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL line_extra got %b want no bit", tx_line);
        end else begin
          e = exp_q.pop_front();
          if (tx_line !== e) begin
            errors++;
            $display("FAIL line_bit got %b want %b", tx_line, e);
          end
        end
      end
    end
  endtask

  task automatic expect_bits(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i] == "1");
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = b;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] nb, input logic pen,
                         input logic podd, input logic s2);
    cfg_data_bits  = nb;
    cfg_parity_en  = pen;
    cfg_parity_odd = podd;
    cfg_stop2      = s2;
  endtask

  task automatic run_frames(input int max_clks, input int exp_len,
                            input int exp_done, input string name);
    int d0, n, len;
    d0 = done_cnt;
    n = 0;
    len = 0;
    @(negedge clk);
    while (!tx_busy && n < max_clks) begin
      @(negedge clk);
      n++;
    end
    if (!tx_busy) begin
      chk({name, "_start"}, tx_busy, 1);
      return;
    end
    while (tx_busy && len < max_clks) begin
      len++;
      @(negedge clk);
    end
    if (exp_len > 0) chk({name, "_len"}, len, exp_len);
    chk({name, "_busy_end"}, tx_busy, 0);
    repeat (3) @(negedge clk);
    chk({name, "_done"}, done_cnt - d0, exp_done);
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_line", tx_line, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_count", fifo_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick_en = 1'b1;
    mon_en = 1'b1;

    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    expect_bits("0101001011");
    push(8'hA5);
    run_frames(300, 60, 1, "f8n1");

    set_cfg(2'd3, 1'b1, 1'b0, 1'b0);
    expect_bits("01010010101");
    push(8'hA5);
    run_frames(300, 66, 1, "f8e1");

    set_cfg(2'd3, 1'b1, 1'b1, 1'b0);
    expect_bits("01010010111");
    push(8'hA5);
    run_frames(300, 66, 1, "f8o1");

    set_cfg(2'd0, 1'b0, 1'b0, 1'b1);
    expect_bits("01111111");
    push(8'hFF);
    run_frames(300, 48, 1, "f5n2");

    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    tick_en = 1'b0;
    repeat (3) @(posedge clk);
    expect_bits("0100000001");
    expect_bits("0000000011");
    expect_bits("0001111001");
    expect_bits("0101010101");
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data = 8'h01;
    @(posedge clk); #1;
    tx_data = 8'h80;
    @(posedge clk); #1;
    tx_data = 8'h3C;
    @(posedge clk); #1;
    tx_data = 8'h55;
    @(posedge clk); #1;
    tx_data = 8'hFF;
    @(negedge clk);
    chk("full_ready", tx_ready, 0);
    chk("full_count", fifo_count, 4);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("drop_count", fifo_count, 4);
    chk("drop_ready", tx_ready, 0);
    tick_en = 1'b1;
    run_frames(600, 240, 4, "burst");

    tick_en = 1'b0;
    repeat (3) @(posedge clk);
    expect_bits("0100000001");
    expect_bits("0000000011");
    expect_bits("0001111001");
    push(8'h01);
    push(8'h80);
    @(negedge clk);
    chk("pp_pre_count", fifo_count, 2);
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    man_tick = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    man_tick = 1'b0;
    @(negedge clk);
    chk("pp_count", fifo_count, 2);
    chk("pp_busy", tx_busy, 1);
    tick_en = 1'b1;
    run_frames(800, 0, 3, "pushpop");

    mon_en = 1'b0;
    push(8'h00);
    push(8'h00);
    n = 0;
    while (!tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ar_pre_busy", tx_busy, 1);
    repeat (20) @(negedge clk);
    chk("ar_pre_line", tx_line, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_line", tx_line, 1);
    chk("ar_count", fifo_count, 0);
    chk("ar_busy", tx_busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    repeat (150) begin
      @(negedge clk);
      if (tx_busy) n++;
    end
    chk("ar_quiet", n, 0);
    chk("ar_count_after", fifo_count, 0);

    mon_en = 1'b1;
    expect_bits("0101001011");
    push(8'hA5);
    run_frames(300, 60, 1, "recover");

    chk("sb_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
